// File: rtl/mips_cpu_pkg.sv
// ============================================================================
// Module   : mips_cpu_pkg
// Brief    : Shared store-opcode constants and store FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_cpu_pkg;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } store_state_t;

endpackage

`default_nettype wire

// File: rtl/mips_cpu_store_unit_if.sv
// ============================================================================
// Module   : mips_cpu_store_unit_if
// Brief    : Core store request handshake plus Avalon-MM write bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mips_cpu_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] rt_data;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        stall;
  logic        done;
  logic        fault;

  // Store unit side: serves the core, drives the bus.
  modport slave (
    input  req_valid, opcode, addr, rt_data, avm_waitrequest,
    output req_ready, avm_address, avm_write, avm_writedata, avm_byteenable,
           stall, done, fault
  );

  // Environment side: core plus bus slave.
  modport master (
    output req_valid, opcode, addr, rt_data, avm_waitrequest,
    input  req_ready, avm_address, avm_write, avm_writedata, avm_byteenable,
           stall, done, fault
  );

endinterface

`default_nettype wire

// File: rtl/mips_cpu_store_align.sv
// ============================================================================
// Module   : mips_cpu_store_align
// Brief    : Byte-lane and data alignment for sb/sh/sw/swl/swr.
//            STORE_ALIGN_CHECK_EN enables sh/sw misalignment detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_cpu_store_align
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] rt_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        supported_o,
  output logic        misaligned_o
);

  logic [4:0] w_shl;
  logic [4:0] w_shr;

  // swr shifts left by a bytes, swl shifts right by (3-a) bytes; ~a == 3-a.
  assign w_shl = {a_i, 3'b000};
  assign w_shr = {~a_i, 3'b000};

  always_comb begin
    be_o         = 4'b0000;
    data_o       = 32'h0000_0000;
    supported_o  = 1'b0;
    misaligned_o = 1'b0;
    case (opcode_i)
      OP_SB: begin
        be_o        = 4'b0001 << a_i;
        data_o      = {4{rt_i[7:0]}};
        supported_o = 1'b1;
      end
      OP_SH: begin
        be_o        = a_i[1] ? 4'b1100 : 4'b0011;
        data_o      = {2{rt_i[15:0]}};
        supported_o = 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
        misaligned_o = a_i[0];
`endif
      end
      OP_SW: begin
        be_o        = 4'b1111;
        data_o      = rt_i;
        supported_o = 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
        misaligned_o = |a_i;
`endif
      end
      OP_SWL: begin
        be_o        = 4'b1111 >> ~a_i;
        data_o      = rt_i >> w_shr;
        supported_o = 1'b1;
      end
      OP_SWR: begin
        be_o        = 4'b1111 << a_i;
        data_o      = rt_i << w_shl;
        supported_o = 1'b1;
      end
      default: begin
        supported_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_cpu_store_unit.sv
// ============================================================================
// Module   : mips_cpu_store_unit
// Brief    : Store request to single Avalon-MM word write with core stall.
//            STORE_ALIGN_CHECK_EN turns misaligned sh/sw into faults.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_cpu_store_unit
  import mips_cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  mips_cpu_store_unit_if.slave   bus
);

  logic [3:0]  w_be;
  logic [31:0] w_data;
  logic        w_supported;
  logic        w_misaligned;

  store_state_t state_q;
  logic         ready_q;
  logic         write_q;
  logic         done_q;
  logic         fault_q;
  logic [31:0]  addr_q;
  logic [31:0]  data_q;
  logic [3:0]   be_q;

  mips_cpu_store_align u_align (
    .opcode_i     (bus.opcode),
    .a_i          (bus.addr[1:0]),
    .rt_i         (bus.rt_data),
    .be_o         (w_be),
    .data_o       (w_data),
    .supported_o  (w_supported),
    .misaligned_o (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= {bus.addr[31:2], 2'b00};
            data_q  <= w_data;
            be_q    <= w_be;
            ready_q <= 1'b0;
            if (w_supported && !w_misaligned) begin
              write_q <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              done_q  <= 1'b1;
              fault_q <= w_misaligned;
              state_q <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (!bus.avm_waitrequest) begin
            write_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          write_q <= 1'b0;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ready_q is high exactly in IDLE, write_q exactly in WRITE.
  assign bus.req_ready      = ready_q;
  assign bus.stall          = (bus.req_valid & ready_q) | write_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = data_q;
  assign bus.avm_byteenable = be_q;
  assign bus.done           = done_q;
  assign bus.fault          = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_store_unit.sv
// ============================================================================
// Module   : tb_mips_cpu_store_unit
// Brief    : Directed plus randomized store transactions against a lane model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips_cpu_store_unit;

  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SWL = 6'b101010;
  localparam logic [5:0] SWR = 6'b101110;
  localparam logic [5:0] LW  = 6'b100011;

  logic clk;
  logic reset;
  int   nchk;
  int   nfail;

  mips_cpu_store_unit_if bus_if ();

  mips_cpu_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Regions start 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-lane model: which rt byte (if any) lands in each lane.
  function automatic void model(input logic [5:0] op, input logic [31:0] ad,
                                input logic [31:0] rt, output logic [3:0] be,
                                output logic [31:0] data, output bit issue,
                                output bit flt);
    int a;
    int src;
    bit sup;
    a    = int'(ad[1:0]);
    be   = 4'b0000;
    data = 32'h0;
    sup  = 1'b1;
    flt  = 1'b0;
    for (int n = 0; n < 4; n++) begin
      src = -1;
      case (op)
        SB:      begin be[n] = (n == a);               src = 0;         end
        SH:      begin be[n] = ((n / 2) == int'(ad[1])); src = n % 2;   end
        SW:      begin be[n] = 1'b1;                   src = n;         end
        SWL:     begin be[n] = (n <= a);               src = n + 3 - a; end
        SWR:     begin be[n] = (n >= a);               src = n - a;     end
        default: sup = 1'b0;
      endcase
      if (src >= 0 && src <= 3) data[8*n +: 8] = rt[8*src +: 8];
    end
`ifdef STORE_ALIGN_CHECK_EN
    flt = (op == SH && ad[0]) || (op == SW && a != 0);
`endif
    issue = sup && !flt;
  endfunction

  // One transaction. With overlap=1 the request is first presented during the
  // previous DONE cycle and must still be taken once the unit is back in IDLE.
  task automatic do_store(input logic [5:0] op, input logic [31:0] ad,
                          input logic [31:0] rt, input int waits,
                          input bit overlap, output logic [3:0] obe,
                          output logic [31:0] odata);
    logic [3:0]  ebe;
    logic [31:0] edata;
    bit          issue;
    bit          flt;
    model(op, ad, rt, ebe, edata, issue, flt);
    obe   = 4'b0000;
    odata = 32'h0;
    if (overlap) begin
      bus_if.req_valid = 1'b1;
      bus_if.opcode    = op;
      bus_if.addr      = ad;
      bus_if.rt_data   = rt;
      #1;
      chk("overlap stall in done", {31'b0, bus_if.stall}, 32'd0);
      step();
    end else begin
      step();
      bus_if.req_valid = 1'b1;
      bus_if.opcode    = op;
      bus_if.addr      = ad;
      bus_if.rt_data   = rt;
    end
    #1;
    chk("idle stall", {31'b0, bus_if.stall}, 32'd1);
    chk("idle ready", {31'b0, bus_if.req_ready}, 32'd1);
    step();
    bus_if.req_valid = 1'b0;
    bus_if.opcode    = 6'($urandom);
    bus_if.addr      = $urandom;
    bus_if.rt_data   = $urandom;
    if (issue) begin
      for (int w = 0; w <= waits; w++) begin
        bus_if.avm_waitrequest = (w < waits);
        #1;
        chk("write strobe", {31'b0, bus_if.avm_write}, 32'd1);
        chk("write address", bus_if.avm_address, {ad[31:2], 2'b00});
        chk("write data", bus_if.avm_writedata, edata);
        chk("write be", {28'b0, bus_if.avm_byteenable}, {28'b0, ebe});
        chk("write stall", {31'b0, bus_if.stall}, 32'd1);
        chk("write no done", {31'b0, bus_if.done}, 32'd0);
        obe   = bus_if.avm_byteenable;
        odata = bus_if.avm_writedata;
        step();
      end
    end
    bus_if.avm_waitrequest = 1'b0;
    #1;
    chk("done pulse", {31'b0, bus_if.done}, 32'd1);
    chk("done fault", {31'b0, bus_if.fault}, {31'b0, flt});
    chk("done write low", {31'b0, bus_if.avm_write}, 32'd0);
    chk("done stall", {31'b0, bus_if.stall}, 32'd0);
    chk("done ready", {31'b0, bus_if.req_ready}, 32'd0);
  endtask

  initial begin : main
    logic [3:0]  obe;
    logic [31:0] odata;
    logic [5:0]  ops [7];
    nchk  = 0;
    nfail = 0;
    ops[0] = SB; ops[1] = SH; ops[2] = SW; ops[3] = SWL; ops[4] = SWR; ops[5] = LW;

    // Reset values, with req_valid high to show stall follows it.
    reset                  = 1'b1;
    bus_if.req_valid       = 1'b1;
    bus_if.opcode          = SW;
    bus_if.addr            = 32'h0;
    bus_if.rt_data         = 32'h0;
    bus_if.avm_waitrequest = 1'b0;
    step();
    step();
    #1;
    chk("rst write", {31'b0, bus_if.avm_write}, 32'd0);
    chk("rst address", bus_if.avm_address, 32'h0);
    chk("rst data", bus_if.avm_writedata, 32'h0);
    chk("rst be", {28'b0, bus_if.avm_byteenable}, 32'h0);
    chk("rst done", {31'b0, bus_if.done}, 32'd0);
    chk("rst fault", {31'b0, bus_if.fault}, 32'd0);
    chk("rst ready", {31'b0, bus_if.req_ready}, 32'd1);
    chk("rst stall follows valid", {31'b0, bus_if.stall}, 32'd1);
    bus_if.req_valid = 1'b0;
    #1;
    chk("rst stall idle", {31'b0, bus_if.stall}, 32'd0);
    step();
    reset = 1'b0;

    do_store(SB, 32'h0000_1003, 32'h0000_00A5, 0, 1'b0, obe, odata);
    chk("sb be", {28'b0, obe}, 32'b1000);
    chk("sb data", odata, 32'hA5A5_A5A5);

    do_store(SWL, 32'h0000_2001, 32'h1122_3344, 0, 1'b0, obe, odata);
    chk("swl be", {28'b0, obe}, 32'b0011);
    chk("swl data", odata, 32'h0000_1122);

    do_store(SWR, 32'h0000_2001, 32'h1122_3344, 0, 1'b1, obe, odata);
    chk("swr be", {28'b0, obe}, 32'b1110);
    chk("swr data", odata, 32'h2233_4400);

    do_store(SW, 32'h0000_3000, 32'hDEAD_BEEF, 3, 1'b0, obe, odata);
    chk("sw wait data", odata, 32'hDEAD_BEEF);

    do_store(SH, 32'h0000_4003, 32'h0000_BEEF, 0, 1'b0, obe, odata);
`ifndef STORE_ALIGN_CHECK_EN
    chk("sh be", {28'b0, obe}, 32'b1100);
    chk("sh data", odata, 32'hBEEF_BEEF);
`endif

    do_store(LW, 32'h0000_5000, 32'h1234_5678, 0, 1'b1, obe, odata);

    // Reset while the write is stalled abandons it without a done pulse.
    step();
    bus_if.req_valid = 1'b1;
    bus_if.opcode    = SW;
    bus_if.addr      = 32'h0000_6000;
    bus_if.rt_data   = 32'hCAFE_F00D;
    step();
    bus_if.req_valid       = 1'b0;
    bus_if.avm_waitrequest = 1'b1;
    #1;
    chk("abort pre write", {31'b0, bus_if.avm_write}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_if.avm_waitrequest = 1'b0;
    #1;
    chk("abort write low", {31'b0, bus_if.avm_write}, 32'd0);
    chk("abort ready", {31'b0, bus_if.req_ready}, 32'd1);
    chk("abort no done", {31'b0, bus_if.done}, 32'd0);
    step();
    chk("abort still no done", {31'b0, bus_if.done}, 32'd0);

    // Randomized mix, including unsupported opcodes and back-to-back requests.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      ops[6] = 6'($urandom);
      op = ops[$urandom_range(0, 6)];
      do_store(op, $urandom, $urandom, int'($urandom_range(0, 3)),
               (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0, obe, odata);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_cpu_store_unit.md
# mips_cpu_store_unit

Store-side memory interface for the multi-cycle MIPS core, the write-direction counterpart to the register file's partial-load merging. Accepts one store request per transaction (`sb`, `sh`, `sw`, `swl`, `swr`) and computes the byte lanes and lane-aligned write data. Issues a single word-aligned write on the Avalon-MM data bus, honouring `waitrequest`, and stalls the core until the write completes.

## Interface
- No parameters. Data/address width is fixed at 32, byte lanes at 4.
- `clk` in 1: the only clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core presents a store request.
- `req_ready` out 1: unit idle and can accept a request.
- `opcode` in 6: instruction opcode field.
- `addr` in 32: effective byte address (base + sign-extended offset).
- `rt_data` in 32: register `rt` value to be stored.
- `avm_address` out 32: word address `{addr[31:2],2'b00}`.
- `avm_write` out 1: bus write strobe.
- `avm_writedata` out 32: lane-aligned store data.
- `avm_byteenable` out 4: active lanes; bit n covers `[8n+7:8n]`.
- `avm_waitrequest` in 1: slave stall.
- `stall` out 1: core must hold the pipeline.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: misaligned-store flag, valid only with `done`.

## Operation
- Opcodes (little-endian lanes; `a` = `addr[1:0]`):
  - `sb` 101000: be = `1<<a`; data = `{4{rt[7:0]}}`.
  - `sh` 101001: a=00 gives be 0011; a=10 gives be 1100. data = `{2{rt[15:0]}}`.
  - `sw` 101011: be 1111; data = rt.
  - `swl` 101010: data = `rt >> 8*(3-a)`; be = 0001, 0011, 0111, 1111 for a = 0..3.
  - `swr` 101110: data = `rt << 8*a`; be = 1111, 1110, 1100, 1000 for a = 0..3.
  - Any other opcode: accepted, no bus write, `done` pulses, `fault` = 0.
- FSM states are IDLE, WRITE and DONE.
  - IDLE: `req_ready` = 1. On `req_valid`, register address, data and byteenable. Go to WRITE, or to DONE for an unsupported opcode or a faulted store.
  - WRITE: `avm_write` = 1. Address, data and byteenable are held stable. Stay while `avm_waitrequest` = 1. When it is 0 the write completes that cycle; go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then IDLE.
- `stall` = (`req_valid` & IDLE) | WRITE. It is low in DONE, so the core advances on `done`.
- Bus outputs reset to 0 and keep their last value outside WRITE; only `avm_write` qualifies them.

## Timing
- Reset values:
  - state IDLE.
  - `avm_write`, `avm_address`, `avm_writedata`, `avm_byteenable`, `done`, `fault` = 0.
  - `req_ready` = 1.
  - `stall` = `req_valid`.
- Latency, zero wait:
  - accept at edge 0.
  - `avm_write` high during cycle 1.
  - `done` during cycle 2.
- Each wait cycle adds one cycle. Throughput is one store per 3 cycles minimum.
- `req_valid` is ignored outside IDLE. Input changes during WRITE or DONE have no effect.
- Reset asserted in WRITE: `avm_write` drops at that edge, the write is abandoned, and no `done` is produced.
- `done` and a new request in the same cycle: the request waits for IDLE on the next cycle; no request is lost or merged.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined:
  - `sh` with `addr[0]`=1 or `sw` with `a`≠00 goes IDLE→DONE with no bus write.
  - `fault` = 1 during that DONE cycle.
- Not defined:
  - `fault` is tied 0.
  - `sh` uses `addr[1]` only; `sw` ignores `addr[1:0]`.
  - The write is always issued.

## Structure
- Shared package `mips_cpu_pkg`:
  - opcode constants `OP_SB`, `OP_SH`, `OP_SW`, `OP_SWL`, `OP_SWR`.
  - store FSM state enum `store_state_t`.
- Sub-module `mips_cpu_store_align`: combinational (opcode, `a`, `rt_data`) → (byteenable, writedata, supported, misaligned). It is instantiated once and registered at accept.

## Test plan
- `sb`, addr 0x1003, rt 0x000000A5, waitrequest 0 → cycle 1: address 0x1000, be 1000, data 0xA5A5A5A5, write 1; `done` in cycle 2.
- `swl`, addr 0x2001, rt 0x11223344 → be 0011, data 0x00001122. `swr`, addr 0x2001, same rt → be 1110, data 0x22334400.
- `sw`, addr 0x3000, rt 0xDEADBEEF, waitrequest held 3 cycles → write high 4 cycles with outputs stable; `done` in cycle 5; `stall` high cycles 0–4.
- `sh`, addr 0x4003 → with `STORE_ALIGN_CHECK_EN`: no write, `done` and `fault` = 1 in cycle 1. Without it: be 1100, data `{2{rt[15:0]}}`, `fault` = 0.
- Reset asserted during WRITE with waitrequest 1 → next cycle `avm_write` = 0, `req_ready` = 1, no `done` pulse.
- Opcode 100011 (`lw`) with `req_valid` → no write, `done` pulse in cycle 1, `fault` = 0.
